// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch constants: reset/exception vectors, branch op codes, next-PC select codes.
// No logic state; imported by the fetch controller and its redirect buffer.
package pc_fetch_ctrl_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

   typedef enum logic [2:0] {
      BR_NONE,
      BR_BEQ,
      BR_BNE,
      BR_BLEZ,
      BR_BGTZ,
      BR_BLTZ,
      BR_BGEZ
   } br_op_e;

   typedef enum logic [2:0] {
      NPC_EXC,
      NPC_HOLD,
      NPC_PEND,
      NPC_REDIR,
      NPC_SEQ
   } npc_sel_e;

   // Sequential fetch step; wraps modulo 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Buffers one resolved redirect and the delay-slot marker while fetch is stalled.
// State updates on the clock edge; captures only under stall_f, drains on the first unstalled cycle.
module pc_redirect_buf
   import pc_fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_flush,
   input  logic        i_stall_f,
   input  logic        i_redir_req,
   input  logic [31:0] i_redir_tgt,
   input  logic        i_branch_fire,
   output logic        o_pending_valid,
   output logic [31:0] o_pending_target,
   output logic        o_ds_pending
);

   logic        r_pending_valid;
   logic [31:0] r_pending_target;
   logic        r_ds_pending;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pending_valid  <= 1'b0;
         r_pending_target <= ZERO_WORD;
         r_ds_pending     <= 1'b0;
      end else if (i_flush) begin
         r_pending_valid <= 1'b0;
         r_ds_pending    <= 1'b0;
      end else if (i_stall_f) begin
         // First target wins; a second request while one is buffered is dropped.
         if (i_redir_req && !r_pending_valid) begin
            r_pending_valid  <= 1'b1;
            r_pending_target <= i_redir_tgt;
         end
         if (i_branch_fire) begin
            r_ds_pending <= 1'b1;
         end
      end else begin
         r_pending_valid <= 1'b0;
         r_ds_pending    <= 1'b0;
      end
   end

   assign o_pending_valid  = r_pending_valid;
   assign o_pending_target = r_pending_target;
   assign o_ds_pending     = r_ds_pending;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register with exception/branch/jump redirect and MIPS delay-slot tagging.
// Redirect visible one cycle after acceptance, or the first cycle after stall_f drops.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        dec_valid,
   input  logic        branch_d,
   input  logic        branch_taken_d,
   input  logic [31:0] branch_target_d,
   input  logic        jump_d,
   input  logic [31:0] jump_target_d,
   input  logic        flush_exc,
   input  logic [31:0] exc_pc,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus4_f,
   output logic        in_delayslot_f,
   output logic        pc_misaligned_f,
   output logic        redirect_pending
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic        w_dec_fire;
   logic        w_branch_fire;
   logic        w_redir_req;
   logic [31:0] w_redir_tgt;
   logic        w_pending_valid;
   logic [31:0] w_pending_target;
   logic        w_ds_pending;
   npc_sel_e    w_npc_sel;

   // A held decode instruction is seen only once, on the cycle it is consumed.
   assign w_dec_fire    = dec_valid & ~stall_d;
   assign w_branch_fire = w_dec_fire & branch_d;
   assign w_redir_req   = w_dec_fire & (jump_d | (branch_d & branch_taken_d));
   assign w_redir_tgt   = jump_d ? jump_target_d : branch_target_d;

   pc_redirect_buf u_redirect_buf (
      .clk              (clk),
      .resetn           (resetn),
      .i_flush          (flush_exc),
      .i_stall_f        (stall_f),
      .i_redir_req      (w_redir_req),
      .i_redir_tgt      (w_redir_tgt),
      .i_branch_fire    (w_branch_fire),
      .o_pending_valid  (w_pending_valid),
      .o_pending_target (w_pending_target),
      .o_ds_pending     (w_ds_pending)
   );

   always_comb begin
      w_npc_sel = NPC_SEQ;
      if (flush_exc) begin
         w_npc_sel = NPC_EXC;
      end else if (stall_f) begin
         w_npc_sel = NPC_HOLD;
      end else if (w_pending_valid) begin
         w_npc_sel = NPC_PEND;
      end else if (w_redir_req) begin
         w_npc_sel = NPC_REDIR;
      end
   end

   always_comb begin
      w_pc_next = pc_inc(r_pc);
      case (w_npc_sel)
         NPC_EXC:   w_pc_next = exc_pc;
         NPC_HOLD:  w_pc_next = r_pc;
         NPC_PEND:  w_pc_next = w_pending_target;
         NPC_REDIR: w_pc_next = w_redir_tgt;
         default:   w_pc_next = pc_inc(r_pc);
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign pc_f             = r_pc;
   assign pc_plus4_f       = pc_inc(r_pc);
   assign pc_misaligned_f  = (r_pc[1:0] != 2'b00);
   assign redirect_pending = w_pending_valid;
   // Not-taken branches still own a delay slot, so the flag ignores branch_taken_d.
   assign in_delayslot_f   = ~flush_exc & (w_branch_fire | w_ds_pending);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against a queue-based fetch model.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stall_f, stall_d, dec_valid, branch_d, branch_taken_d, jump_d, flush_exc;
   logic [31:0] branch_target_d, jump_target_d, exc_pc;
   logic [31:0] pc_f, pc_plus4_f;
   logic        in_delayslot_f, pc_misaligned_f, redirect_pending;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_pc;
   logic [31:0] m_pend[$];
   bit          m_ds;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.RESET_PC(RST)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .stall_f          (stall_f),
      .stall_d          (stall_d),
      .dec_valid        (dec_valid),
      .branch_d         (branch_d),
      .branch_taken_d   (branch_taken_d),
      .branch_target_d  (branch_target_d),
      .jump_d           (jump_d),
      .jump_target_d    (jump_target_d),
      .flush_exc        (flush_exc),
      .exc_pc           (exc_pc),
      .pc_f             (pc_f),
      .pc_plus4_f       (pc_plus4_f),
      .in_delayslot_f   (in_delayslot_f),
      .pc_misaligned_f  (pc_misaligned_f),
      .redirect_pending (redirect_pending)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic check_all(input bit exp_ds);
      chk("pc_f", pc_f, m_pc);
      chk("pc_plus4_f", pc_plus4_f, m_pc + 32'd4);
      chk("in_delayslot_f", {31'b0, in_delayslot_f}, {31'b0, exp_ds});
      chk("pc_misaligned_f", {31'b0, pc_misaligned_f}, {31'b0, (m_pc[1:0] != 2'b00)});
      chk("redirect_pending", {31'b0, redirect_pending}, {31'b0, (m_pend.size() != 0)});
   endtask

   task automatic model_reset();
      m_pc = RST;
      m_pend.delete();
      m_ds = 1'b0;
   endtask

   task automatic drive_idle();
      stall_f = 0; stall_d = 0; dec_valid = 0; branch_d = 0; branch_taken_d = 0;
      jump_d = 0; flush_exc = 0; branch_target_d = '0; jump_target_d = '0; exc_pc = '0;
   endtask

   // Called at posedge+1; drives one cycle, checks, advances the model, returns at next posedge+1.
   task automatic step(input bit sf, input bit sd, input bit dv, input bit br, input bit tk,
                       input logic [31:0] bt, input bit jp, input logic [31:0] jt,
                       input bit fl, input logic [31:0] ep);
      bit          fire, req;
      logic [31:0] tgt;
      stall_f = sf; stall_d = sd; dec_valid = dv; branch_d = br; branch_taken_d = tk;
      branch_target_d = bt; jump_d = jp; jump_target_d = jt; flush_exc = fl; exc_pc = ep;
      #1;
      fire = dv && !sd;
      req  = fire && (jp || (br && tk));
      tgt  = jp ? jt : bt;
      check_all(!fl && ((fire && br) || m_ds));
      if (fl) begin
         m_pc = ep;
         m_pend.delete();
         m_ds = 1'b0;
      end else if (sf) begin
         if (req && m_pend.size() == 0) m_pend.push_back(tgt);
         if (fire && br) m_ds = 1'b1;
      end else begin
         if (m_pend.size() != 0) m_pc = m_pend.pop_front();
         else if (req) m_pc = tgt;
         else m_pc = m_pc + 32'd4;
         m_ds = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
   endtask

   initial begin
      drive_idle();
      resetn = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all(1'b0);
      chk("reset_pc", pc_f, 32'hBFC0_0000);
      resetn = 1'b1;

      // Straight-line fetch up to BFC00010, then a taken branch there.
      repeat (4) idle();
      chk("seq_pc", pc_f, 32'hBFC0_0010);
      step(0, 0, 1, 1, 1, 32'hBFC0_0100, 0, 32'h0, 0, 32'h0);
      chk("branch_tgt", pc_f, 32'hBFC0_0100);
      idle();

      // Taken branch accepted under a 3-cycle fetch stall.
      step(1, 0, 1, 1, 1, 32'h8000_1000, 0, 32'h0, 0, 32'h0);
      chk("stall_pending", {31'b0, redirect_pending}, 32'd1);
      step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      chk("stall_release_pc", pc_f, 32'h8000_1000);
      chk("stall_release_pend", {31'b0, redirect_pending}, 32'd0);

      // Decode-stalled branch redirects exactly once.
      step(0, 1, 1, 1, 1, 32'h8000_2000, 0, 32'h0, 0, 32'h0);
      step(0, 1, 1, 1, 1, 32'h8000_2000, 0, 32'h0, 0, 32'h0);
      step(0, 0, 1, 1, 1, 32'h8000_2000, 0, 32'h0, 0, 32'h0);
      chk("stall_d_tgt", pc_f, 32'h8000_2000);
      idle();
      chk("stall_d_once", pc_f, 32'h8000_2004);

      // Exception flush wins over a pending redirect and a new branch.
      step(1, 0, 1, 1, 1, 32'h8000_3000, 0, 32'h0, 0, 32'h0);
      step(1, 0, 1, 1, 1, 32'h8000_4000, 0, 32'h0, 1, 32'hBFC0_0380);
      chk("flush_pc", pc_f, 32'hBFC0_0380);
      chk("flush_pend", {31'b0, redirect_pending}, 32'd0);

      // Misaligned JR, then wrap from FFFFFFFC.
      step(0, 0, 1, 0, 0, 32'h0, 1, 32'h8000_0002, 0, 32'h0);
      chk("misaligned_pc", pc_f, 32'h8000_0002);
      chk("misaligned_flag", {31'b0, pc_misaligned_f}, 32'd1);
      step(0, 0, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
      chk("wrap_pre", pc_f, 32'hFFFF_FFFC);
      idle();
      chk("wrap_zero", pc_f, 32'h0000_0000);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] bt, jt, ep;
         bt = $urandom();
         jt = $urandom();
         ep = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0380 : ($urandom() & 32'hFFFF_FFFC);
         if ($urandom_range(0, 7) != 0) bt = bt & 32'hFFFF_FFFC;
         if ($urandom_range(0, 7) != 0) jt = jt & 32'hFFFF_FFFC;
         step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, bt,
              $urandom_range(0, 19) < 3, jt, $urandom_range(0, 19) == 0, ep);
      end

      // Reset asserted mid-stall with a redirect buffered.
      step(1, 0, 1, 1, 1, 32'h8000_5000, 0, 32'h0, 0, 32'h0);
      step(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      drive_idle();
      resetn = 1'b0;
      #1;
      chk("midreset_pc", pc_f, RST);
      chk("midreset_pend", {31'b0, redirect_pending}, 32'd0);
      chk("midreset_ds", {31'b0, in_delayslot_f}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      check_all(1'b0);
      resetn = 1'b1;
      repeat (3) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage program-counter controller for the 5-stage MIPS pipeline.
- Consumes the decode-stage branch decision (taken/not-taken plus target) and jump targets, and applies exception redirects.
- Implements the MIPS branch delay slot.
- Holds a pending redirect when fetch is stalled on instruction memory, so a resolved branch is never lost.
- Drives pc_f to the instruction SRAM and tags each fetched instruction with its delay-slot status.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- stall_f  in  1  fetch stall: hold PC (instruction memory not ready, or hazard)
- stall_d  in  1  decode stall: decode instruction held, its outputs not consumed
- dec_valid  in  1  decode stage holds a valid instruction
- branch_d  in  1  decode instruction is a branch/jump class instruction (has a delay slot)
- branch_taken_d  in  1  branch-decision result for the decode instruction
- branch_target_d  in  32  PC-relative branch target
- jump_d  in  1  decode instruction is J/JAL/JR/JALR (unconditional)
- jump_target_d  in  32  jump target (immediate or forwarded register)
- flush_exc  in  1  exception/ERET redirect from the commit stage
- exc_pc  in  32  redirect address (exception vector or EPC)
- pc_f  out  32  current fetch PC
- pc_plus4_f  out  32  pc_f + 4
- in_delayslot_f  out  1  instruction at pc_f is a branch delay slot
- pc_misaligned_f  out  1  pc_f[1:0] != 0 (AdEL source)
- redirect_pending  out  1  a resolved redirect is buffered, awaiting fetch

Behaviour:
- Reset (async, resetn=0): pc_f=RESET_PC; pending_valid=0; pending_target=0; ds_pending=0. All outputs derive from these registers: pc_plus4_f=RESET_PC+4, in_delayslot_f=0, pc_misaligned_f=0, redirect_pending=0.
- Accept rule: dec_fire = dec_valid & ~stall_d. Decode inputs are ignored when dec_fire=0, so a stalled branch is never double-counted.
- Redirect request:
  - redir_req = dec_fire & (jump_d | (branch_d & branch_taken_d)).
  - redir_tgt = jump_d ? jump_target_d : branch_target_d.
  - jump_d has priority if both jump_d and branch_d are set.
- Next-PC priority, evaluated every cycle and registered on the clk rising edge:
  1. flush_exc=1: pc_f<=exc_pc, even when stall_f=1. Clears pending_valid and ds_pending. A simultaneous redir_req is discarded.
  2. Else if stall_f=1: pc_f holds.
     - If redir_req and !pending_valid: pending_valid<=1, pending_target<=redir_tgt.
     - If branch_d & dec_fire: ds_pending<=1.
  3. Else if pending_valid: pc_f<=pending_target; pending_valid<=0.
  4. Else if redir_req: pc_f<=redir_tgt.
  5. Else: pc_f<=pc_f+4.
  - Steps 3–5 also clear ds_pending.
- Redirect latency: when a taken branch is accepted in cycle N, the delay slot is the instruction fetched at pc_f in cycle N. The target appears on pc_f in cycle N+1, or in the first cycle after stall_f deasserts.
- A second redir_req while pending_valid=1 cannot occur: the delay slot is not a branch, and this is architecturally undefined. The block keeps the first target and ignores the second.
- Delay slot flag:
  - in_delayslot_f = ~flush_exc & ((dec_fire & branch_d) | ds_pending).
  - The flag is asserted for not-taken branches too.
- Arithmetic: pc+4 is unsigned modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Targets are not checked for alignment. A misaligned target is loaded as-is and flagged combinationally on pc_misaligned_f.
- redirect_pending = pending_valid.
- Reset asserted mid-stall discards all pending state immediately.

Decomposition:
- Shared defines header holds RESET_PC and the exception vector constants (32'hBFC0_0380), next to ZeroWord and the branch op codes.
- One natural sub-module: pc_redirect_buf (pending_valid/pending_target/ds_pending with capture and clear logic).
- The PC register and next-PC mux stay in the top module.

Test Plan:
- Reset release, no stalls, no branches → pc_f sequence BFC00000, BFC00004, BFC00008; in_delayslot_f=0 throughout.
- At pc_f=BFC00010, taken branch accepted with target BFC00100 → in_delayslot_f=1 that cycle; next cycle pc_f=BFC00100, in_delayslot_f=0.
- Taken branch (target 80001000) accepted while stall_f=1 for 3 cycles:
  - pc_f holds.
  - redirect_pending=1 and in_delayslot_f=1 during the stall.
  - First cycle after release: pc_f=80001000, redirect_pending=0.
- stall_d=1 with a taken branch held for 2 cycles, then released → only one redirect; pc_f sequence shows the target exactly once, with no extra pending capture.
- flush_exc=1, exc_pc=BFC00380, in the same cycle as a taken branch with a pending redirect and stall_f=1 → next cycle pc_f=BFC00380; redirect_pending=0; in_delayslot_f=0.
- Misaligned JR to 80000002 → pc_f=80000002, pc_misaligned_f=1; then pc_f=0xFFFFFFFC followed by the wrap to 00000000.
